// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT pipeline stages.
// Widths are given as <int.frac> signed fixed point.
package fft_pkg;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned FRAC   = 6;
    localparam int unsigned W_IN   = 10;  // <4.6>
    localparam int unsigned W_OUT  = 11;  // <5.6>
    localparam int unsigned W_TW   = 13;  // <7.6>
    localparam int unsigned SR_LEN = 2;

    typedef struct packed {
        logic signed [W_IN-1:0] R;
        logic signed [W_IN-1:0] Q;
    } cplx_in_t;

    typedef struct packed {
        logic signed [W_OUT-1:0] R;
        logic signed [W_OUT-1:0] Q;
    } cplx_out_t;

    typedef struct packed {
        logic signed [W_TW-1:0] R;
        logic signed [W_TW-1:0] Q;
    } cplx_tw_t;

    typedef enum logic {StFill, StCalc} bfly_state_e;

    function automatic cplx_out_t cplx_sext(cplx_in_t x);
        cplx_out_t y;
        y.R = W_OUT'(x.R);
        y.Q = W_OUT'(x.Q);
        return y;
    endfunction

endpackage

// File: rtl/bfly_sr_1_if.sv
// Sample-stream bus between the butterfly stage and its neighbours.
// master drives samples in and observes results; slave is the butterfly side.
interface bfly_sr_1_if #(
    parameter int unsigned WIDTH      = fft_pkg::W_IN,
    parameter int unsigned DOUT_WIDTH = WIDTH + 1,
    parameter int unsigned DEPTH      = fft_pkg::DEPTH
) ();

    logic                                 din_valid;
    logic                                 din_sof;
    logic [DEPTH-1:0][WIDTH-1:0]          din_R;
    logic [DEPTH-1:0][WIDTH-1:0]          din_Q;
    logic                                 dout_valid;
    logic [1:0]                           select;
    logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_R_add;
    logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_Q_add;
    logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_R_sub;
    logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_Q_sub;
    logic                                 sync_err;

    modport master (
        output din_valid, din_sof, din_R, din_Q,
        input  dout_valid, select, dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub, sync_err
    );

    modport slave (
        input  din_valid, din_sof, din_R, din_Q,
        output dout_valid, select, dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub, sync_err
    );

endinterface

// File: rtl/bfly_ctrl.sv
// Frame sequencing for the butterfly stage: phase counter, FILL/CALC FSM,
// SOF resync and the twiddle select counter.
module bfly_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned SrLen = fft_pkg::SR_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_valid,
    input  logic       din_sof,
    output logic       shift_en,
    output logic       calc_en,
    output logic       clr,
    output logic       dout_valid,
    output logic [1:0] select,
    output logic       sync_err
);

    localparam int unsigned FrameLen = 2 * SrLen;
    localparam int unsigned PhW      = $clog2(FrameLen);
    localparam logic [PhW-1:0] PhLast = PhW'(FrameLen - 1);
    localparam logic [PhW-1:0] PhCalc = PhW'(SrLen);

    bfly_state_e    state_q, state_d;
    logic [PhW-1:0] ph_q, ph_d;
    logic [1:0]     sel_cnt_q;
    logic [1:0]     select_q;
    logic           dout_valid_q;
    logic           sync_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            ph_q    <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
        end
    end

    // An SOF beat always occupies phase 0, so the next beat is phase 1.
    always_comb begin
        ph_d = ph_q;
        if (din_valid) begin
            if (din_sof) begin
                ph_d = PhW'(1);
            end else if (ph_q == PhLast) begin
                ph_d = '0;
            end else begin
                ph_d = ph_q + PhW'(1);
            end
        end
        state_d = (ph_d >= PhCalc) ? StCalc : StFill;
    end

    always_comb begin
        shift_en = din_valid;
        clr      = din_valid && din_sof;
        calc_en  = din_valid && !din_sof && (state_q == StCalc);
    end

    // select_q carries the index of the beat being output; sel_cnt_q the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            sel_cnt_q    <= 2'd0;
            select_q     <= 2'd0;
        end else begin
            dout_valid_q <= calc_en;
            sync_err_q   <= clr && (ph_q != '0);
            if (clr) begin
                sel_cnt_q <= 2'd0;
                select_q  <= 2'd0;
            end else if (calc_en) begin
                select_q  <= sel_cnt_q;
                sel_cnt_q <= sel_cnt_q + 2'd1;
            end
        end
    end

    assign dout_valid = dout_valid_q;
    assign select     = select_q;
    assign sync_err   = sync_err_q;

endmodule

// File: rtl/bfly_sr_1.sv
// Radix-2 butterfly with a block delay buffer: first half of each frame is held,
// second half is combined lane-wise into full-precision sums and differences.
module bfly_sr_1 #(
    parameter int unsigned WIDTH      = fft_pkg::W_IN,
    parameter int unsigned DOUT_WIDTH = WIDTH + 1,
    parameter int unsigned DEPTH      = fft_pkg::DEPTH,
    parameter int unsigned SR_LEN     = fft_pkg::SR_LEN
) (
    input logic        clk,
    input logic        rst,
    bfly_sr_1_if.slave bus
);

    logic shift_en;
    logic calc_en;
    logic clr;

    bfly_ctrl #(
        .SrLen (SR_LEN)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (bus.din_valid),
        .din_sof    (bus.din_sof),
        .shift_en   (shift_en),
        .calc_en    (calc_en),
        .clr        (clr),
        .dout_valid (bus.dout_valid),
        .select     (bus.select),
        .sync_err   (bus.sync_err)
    );

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_lane
        logic signed [WIDTH-1:0]      buf_re_q [SR_LEN];
        logic signed [WIDTH-1:0]      buf_im_q [SR_LEN];
        logic signed [WIDTH-1:0]      d_re, d_im;
        logic signed [DOUT_WIDTH-1:0] bx_re, bx_im, dx_re, dx_im;
        logic signed [DOUT_WIDTH-1:0] add_re_q, add_im_q, sub_re_q, sub_im_q;

        assign d_re = $signed(bus.din_R[g]);
        assign d_im = $signed(bus.din_Q[g]);

        // Index 0 is the oldest beat; new beats enter at the tail.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < int'(SR_LEN); k++) begin
                    buf_re_q[k] <= '0;
                    buf_im_q[k] <= '0;
                end
            end else if (clr) begin
                for (int k = 0; k < int'(SR_LEN) - 1; k++) begin
                    buf_re_q[k] <= '0;
                    buf_im_q[k] <= '0;
                end
                buf_re_q[SR_LEN-1] <= d_re;
                buf_im_q[SR_LEN-1] <= d_im;
            end else if (shift_en) begin
                for (int k = 0; k < int'(SR_LEN) - 1; k++) begin
                    buf_re_q[k] <= buf_re_q[k+1];
                    buf_im_q[k] <= buf_im_q[k+1];
                end
                buf_re_q[SR_LEN-1] <= d_re;
                buf_im_q[SR_LEN-1] <= d_im;
            end
        end

        assign bx_re = DOUT_WIDTH'(buf_re_q[0]);
        assign bx_im = DOUT_WIDTH'(buf_im_q[0]);
        assign dx_re = DOUT_WIDTH'(d_re);
        assign dx_im = DOUT_WIDTH'(d_im);

        always_ff @(posedge clk) begin
            if (rst) begin
                add_re_q <= '0;
                add_im_q <= '0;
                sub_re_q <= '0;
                sub_im_q <= '0;
            end else if (calc_en) begin
                add_re_q <= bx_re + dx_re;
                add_im_q <= bx_im + dx_im;
                sub_re_q <= bx_re - dx_re;
                sub_im_q <= bx_im - dx_im;
            end
        end

        assign bus.dout_R_add[g] = add_re_q;
        assign bus.dout_Q_add[g] = add_im_q;
        assign bus.dout_R_sub[g] = sub_re_q;
        assign bus.dout_Q_sub[g] = sub_im_q;
    end

endmodule

// File: tb/tb_bfly_sr_1.sv
// Directed bench for bfly_sr_1: steady frame, extremes, valid gap, resync,
// back-to-back frames and mid-frame reset, all against hand-computed values.
module tb_bfly_sr_1;

    localparam int unsigned W  = 10;
    localparam int unsigned NL = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    bfly_sr_1_if bus ();

    bfly_sr_1 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected lane i value = base + i*inc for each of the four result buses.
    task automatic chk_out(input string tag,
                           input int ra0, input int rai, input int rs0, input int rsi,
                           input int qa0, input int qai, input int qs0, input int qsi);
        for (int i = 0; i < int'(NL); i++) begin
            chk($sformatf("%s.l%0d.R_add", tag, i), $signed(bus.dout_R_add[i]), ra0 + i * rai);
            chk($sformatf("%s.l%0d.R_sub", tag, i), $signed(bus.dout_R_sub[i]), rs0 + i * rsi);
            chk($sformatf("%s.l%0d.Q_add", tag, i), $signed(bus.dout_Q_add[i]), qa0 + i * qai);
            chk($sformatf("%s.l%0d.Q_sub", tag, i), $signed(bus.dout_Q_sub[i]), qs0 + i * qsi);
        end
    endtask

    task automatic chk_side(input string tag, input int dv, input int sel, input int se);
        chk({tag, ".dout_valid"}, {31'd0, bus.dout_valid}, dv);
        chk({tag, ".select"}, {30'd0, bus.select}, sel);
        chk({tag, ".sync_err"}, {31'd0, bus.sync_err}, se);
    endtask

    // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic r, input logic v, input logic s,
                        input int rb, input int ri, input int qb, input int qi);
        rst           = r;
        bus.din_valid = v;
        bus.din_sof   = s;
        for (int i = 0; i < int'(NL); i++) begin
            bus.din_R[i] = W'(rb + i * ri);
            bus.din_Q[i] = W'(qb + i * qi);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst           = 1'b1;
        bus.din_valid = 1'b0;
        bus.din_sof   = 1'b0;
        bus.din_R     = '0;
        bus.din_Q     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_side("reset", 0, 0, 0);
        chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);

        // Steady frame
        step(0, 1, 1, 100, 0, 0, 0);
        chk_side("steady.b0", 0, 0, 0);
        step(0, 1, 0, -50, 0, 0, 0);
        chk_side("steady.b1", 0, 0, 0);
        step(0, 1, 0, 30, 0, 0, 0);
        chk_side("steady.b2", 1, 0, 0);
        chk_out("steady.b2", 130, 0, 70, 0, 0, 0, 0, 0);
        step(0, 1, 0, 200, 0, 0, 0);
        chk_side("steady.b3", 1, 1, 0);
        chk_out("steady.b3", 150, 0, -250, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_side("steady.idle", 0, 1, 0);
        chk_out("steady.idle", 150, 0, -250, 0, 0, 0, 0, 0);

        // Extremes
        step(0, 1, 1, -512, 0, 511, 0);
        chk_side("ext.b0", 0, 0, 0);
        step(0, 1, 0, 511, 0, -512, 0);
        step(0, 1, 0, -512, 0, -512, 0);
        chk_side("ext.b2", 1, 0, 0);
        chk_out("ext.b2", -1024, 0, 0, 0, -1, 0, 1023, 0);
        step(0, 1, 0, -512, 0, 511, 0);
        chk_side("ext.b3", 1, 1, 0);
        chk_out("ext.b3", -1, 0, 1023, 0, -1, 0, -1023, 0);

        // Valid gap of three cycles between beat 2 and beat 3 of the frame
        step(0, 1, 1, 100, 0, 0, 0);
        step(0, 1, 0, -50, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 77, 0, 77, 0);
            chk_side($sformatf("gap.idle%0d", k), 0, 0, 0);
        end
        chk_out("gap.hold", -1, 0, 1023, 0, -1, 0, -1023, 0);
        step(0, 1, 0, 30, 0, 0, 0);
        chk_side("gap.b2", 1, 0, 0);
        chk_out("gap.b2", 130, 0, 70, 0, 0, 0, 0, 0);
        step(0, 1, 0, 200, 0, 0, 0);
        chk_side("gap.b3", 1, 1, 0);
        chk_out("gap.b3", 150, 0, -250, 0, 0, 0, 0, 0);

        // Resync: SOF arrives at phase 3
        step(0, 1, 1, 100, 0, 0, 0);
        step(0, 1, 0, -50, 0, 0, 0);
        step(0, 1, 0, 30, 0, 0, 0);
        chk_side("resync.b2", 1, 0, 0);
        step(0, 1, 1, 100, 0, 0, 0);
        chk_side("resync.sof", 0, 0, 1);
        chk_out("resync.sof", 130, 0, 70, 0, 0, 0, 0, 0);
        step(0, 1, 0, -50, 0, 0, 0);
        chk_side("resync.b1", 0, 0, 0);
        step(0, 1, 0, 30, 0, 0, 0);
        chk_side("resync.b2n", 1, 0, 0);
        chk_out("resync.b2n", 130, 0, 70, 0, 0, 0, 0, 0);
        step(0, 1, 0, 200, 0, 0, 0);
        chk_side("resync.b3n", 1, 1, 0);
        chk_out("resync.b3n", 150, 0, -250, 0, 0, 0, 0, 0);

        // Two back-to-back frames, lane-dependent values
        step(0, 1, 1, 0, 1, 10, 0);
        step(0, 1, 0, 0, 2, 20, 0);
        chk_side("b2b.a1", 0, 0, 0);
        step(0, 1, 0, 0, 3, 30, 0);
        chk_side("b2b.a2", 1, 0, 0);
        chk_out("b2b.a2", 0, 4, 0, -2, 40, 0, -20, 0);
        step(0, 1, 0, 0, 4, 40, 0);
        chk_side("b2b.a3", 1, 1, 0);
        chk_out("b2b.a3", 0, 6, 0, -2, 60, 0, -20, 0);
        step(0, 1, 0, 0, -1, -8, 0);
        chk_side("b2b.b0", 0, 1, 0);
        step(0, 1, 0, 5, 0, 7, 0);
        chk_side("b2b.b1", 0, 1, 0);
        step(0, 1, 0, 0, 1, 3, 0);
        chk_side("b2b.b2", 1, 2, 0);
        chk_out("b2b.b2", 0, 0, 0, -2, -5, 0, -11, 0);
        step(0, 1, 0, 0, -3, -6, 0);
        chk_side("b2b.b3", 1, 3, 0);
        chk_out("b2b.b3", 5, -3, 5, 3, 1, 0, 13, 0);

        // Mid-frame reset during a CALC beat
        step(0, 1, 1, 100, 0, 0, 0);
        step(0, 1, 0, -50, 0, 0, 0);
        step(1, 1, 0, 30, 0, 0, 0);
        chk_side("rst.mid", 0, 0, 0);
        chk_out("rst.mid", 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 7, 0, 0, 0);
        chk_side("rst.f0", 0, 0, 0);
        step(0, 1, 0, 8, 0, 0, 0);
        chk_side("rst.f1", 0, 0, 0);
        step(0, 1, 0, 9, 0, 0, 0);
        chk_side("rst.c0", 1, 0, 0);
        chk_out("rst.c0", 16, 0, -2, 0, 0, 0, 0, 0);
        step(0, 1, 0, 10, 0, 0, 0);
        chk_side("rst.c1", 1, 1, 0);
        chk_out("rst.c1", 18, 0, -2, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
